// File: rtl/score_round_controller_pkg.sv
// Purpose : shared types, default timing values and helpers for the scoring-round controller.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package score_round_controller_pkg;

  // Round sequencing states. The 2-bit encoding is kept explicit so that
  // waveform dumps read the same as the original display-path documentation.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAYING   = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  // Default timing for a 50 MHz board clock.
  localparam int DEF_SAMPLE_DIV        = 20000000;
  localparam int DEF_CLK_PER_SEC       = 50000000;
  localparam int DEF_COUNTDOWN_SECONDS = 3;
  localparam int DEF_ROUND_SECONDS     = 30;
  localparam int DEF_SCORE_MAX         = 99;

  // Add one to a score without passing lim. Values already at or above
  // lim return lim, so the score never wraps back to a small number.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v >= lim) r = lim;
    else          r = v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/score_round_controller_tick_divider.sv
// Purpose : free-running clock divider producing a one-cycle tick every DIV clocks.
// Latency : tick is high in the cycle where the count equals DIV-1; the first tick
//           after clear arrives DIV cycles later.
// Backpr. : none. clear restarts the count from zero so the phase follows the caller.
// Ports   : clock, reset (sync, active-high), clear (sync restart) -> tick.
module tick_divider #(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/score_round_controller.sv
// Purpose : sequences one timed scoring round (countdown, play, game over) and
//           tracks the saturating round score and the session high score.
// Latency : all outputs registered; they change on the clock edge that commits
//           the state change. high_score follows one cycle after game_over rises.
// Backpr. : none. start edges are ignored outside IDLE/GAME_OVER.
// Ports   : clock, reset (sync, active-high), start (level button), hit (score input)
//           -> score, high_score, time_left, display_value, round_active, game_over.
module score_round_controller
  import score_round_controller_pkg::*;
#(
  parameter int SAMPLE_DIV        = DEF_SAMPLE_DIV,
  parameter int CLK_PER_SEC       = DEF_CLK_PER_SEC,
  parameter int COUNTDOWN_SECONDS = DEF_COUNTDOWN_SECONDS,
  parameter int ROUND_SECONDS     = DEF_ROUND_SECONDS,
  parameter int SCORE_MAX         = DEF_SCORE_MAX
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [7:0] time_left,
  output logic [7:0] display_value,
  output logic       round_active,
  output logic       game_over
);

  localparam logic [7:0] CD_LOAD   = 8'(COUNTDOWN_SECONDS);
  localparam logic [7:0] RND_LOAD  = 8'(ROUND_SECONDS);
  localparam logic [7:0] SCORE_LIM = 8'(SCORE_MAX);

  state_t     state_q;
  state_t     state_d;
  logic       start_q;
  logic       start_armed;
  logic       start_edge;
  logic       go_first_q;
  logic       state_change;
  logic       sample_tick;
  logic       sec_tick;
  logic [7:0] score_d;
  logic [7:0] high_score_d;
  logic [7:0] time_left_d;

  // Both dividers restart on every state entry so tick phase is aligned to it.
  assign state_change = (state_d != state_q);

  tick_divider #(.DIV(SAMPLE_DIV)) u_sample_div (
    .clock (clock),
    .reset (reset),
    .clear (state_change),
    .tick  (sample_tick)
  );

  tick_divider #(.DIV(CLK_PER_SEC)) u_sec_div (
    .clock (clock),
    .reset (reset),
    .clear (state_change),
    .tick  (sec_tick)
  );

  // start_q alone would see a rising edge if the button is already held when
  // reset releases (start_q comes out of reset low). start_armed only opens
  // once the button has been seen released, so a held button never starts a round.
  assign start_edge = start & ~start_q & start_armed;

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    score_d      = score;
    high_score_d = high_score;
    time_left_d  = time_left;

    // High score is captured in the first GAME_OVER cycle from the final score.
    if ((state_q == ST_GAME_OVER) && go_first_q && (score > high_score)) begin
      high_score_d = score;
    end

    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge) begin
          state_d     = ST_COUNTDOWN;
          score_d     = 8'd0;
          time_left_d = CD_LOAD;
        end
      end

      ST_COUNTDOWN: begin
        if (sec_tick) begin
          if (time_left <= 8'd1) begin
            state_d     = ST_PLAYING;
            time_left_d = RND_LOAD;
          end else begin
            time_left_d = time_left - 8'd1;
          end
        end
      end

      ST_PLAYING: begin
        // A hit on the same cycle as the final second still counts: the score
        // update and the transition below are applied together.
        if (sample_tick && hit) begin
          score_d = sat_inc(score, SCORE_LIM);
        end
        if (sec_tick) begin
          if (time_left <= 8'd1) begin
            state_d     = ST_GAME_OVER;
            time_left_d = 8'd0;
          end else begin
            time_left_d = time_left - 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs. Outputs are driven from the next-state
  // values so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      score         <= 8'd0;
      high_score    <= 8'd0;
      time_left     <= 8'd0;
      display_value <= 8'd0;
      round_active  <= 1'b0;
      game_over     <= 1'b0;
      go_first_q    <= 1'b0;
      start_q       <= 1'b0;
      start_armed   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score         <= score_d;
      high_score    <= high_score_d;
      time_left     <= time_left_d;
      display_value <= (state_d == ST_IDLE) ? high_score_d : score_d;
      round_active  <= (state_d == ST_PLAYING);
      game_over     <= (state_d == ST_GAME_OVER);
      go_first_q    <= (state_d == ST_GAME_OVER) && (state_q != ST_GAME_OVER);
      start_q       <= start;
      if (!start) begin
        start_armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_score_round_controller.sv
// Purpose : directed checks of round sequencing, scoring, saturation and reset handling.
// Latency : n/a.
// Backpr. : n/a.
module tb_score_round_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: main bench timing, SCORE_MAX=99.
  logic       rst_a, start_a, hit_a;
  logic [7:0] score_a, hs_a, tl_a, dv_a;
  logic       ra_a, go_a;

  // Instance B: SCORE_MAX=5, SAMPLE_DIV=5 so a sample tick lands on the final second.
  logic       rst_b, start_b, hit_b;
  logic [7:0] score_b, hs_b, tl_b, dv_b;
  logic       ra_b, go_b;

  score_round_controller #(
    .SAMPLE_DIV(4), .CLK_PER_SEC(10), .COUNTDOWN_SECONDS(2),
    .ROUND_SECONDS(3), .SCORE_MAX(99)
  ) dut_a (
    .clock(clock), .reset(rst_a), .start(start_a), .hit(hit_a),
    .score(score_a), .high_score(hs_a), .time_left(tl_a),
    .display_value(dv_a), .round_active(ra_a), .game_over(go_a)
  );

  score_round_controller #(
    .SAMPLE_DIV(5), .CLK_PER_SEC(10), .COUNTDOWN_SECONDS(2),
    .ROUND_SECONDS(3), .SCORE_MAX(5)
  ) dut_b (
    .clock(clock), .reset(rst_b), .start(start_b), .hit(hit_b),
    .score(score_b), .high_score(hs_b), .time_left(tl_b),
    .display_value(dv_b), .round_active(ra_b), .game_over(go_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; hit_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; hit_b = 1'b0;

    // ---- 1: reset state, countdown timing, entry to PLAYING ----
    step(2);
    chk("a_rst_score", score_a, 0);
    chk("a_rst_hs",    hs_a,    0);
    chk("a_rst_tl",    tl_a,    0);
    chk("a_rst_dv",    dv_a,    0);
    chk("a_rst_ra",    ra_a,    0);
    chk("a_rst_go",    go_a,    0);
    rst_a = 1'b0;
    step(1);
    start_a = 1'b1;
    step(1);                       // E0: COUNTDOWN
    start_a = 1'b0;
    chk("a_cd_tl0", tl_a, 2);
    chk("a_cd_ra0", ra_a, 0);
    step(9);                       // E9
    chk("a_cd_tl9", tl_a, 2);
    step(1);                       // E10
    chk("a_cd_tl10", tl_a, 1);
    step(9);                       // E19
    chk("a_cd_ra19", ra_a, 0);
    step(1);                       // E20: PLAYING
    chk("a_pl_tl", tl_a, 3);
    chk("a_pl_ra", ra_a, 1);

    // ---- 2: hit held for the whole round ----
    hit_a = 1'b1;
    step(20);                      // E40: ticks at 24..40 -> 5
    chk("a_pl_score40", score_a, 5);
    chk("a_pl_tl40",    tl_a,    1);
    step(10);                      // E50: GAME_OVER
    chk("a_go_score", score_a, 7);
    chk("a_go_go",    go_a,    1);
    chk("a_go_ra",    ra_a,    0);
    chk("a_go_tl",    tl_a,    0);
    chk("a_go_hs0",   hs_a,    0);
    step(1);
    hit_a = 1'b0;
    chk("a_go_hs1", hs_a, 7);
    chk("a_go_dv",  dv_a, 7);
    step(3);
    chk("a_go_hold", score_a, 7);

    // ---- 3 + 5: second round with hit=0, stray start pulses ignored ----
    start_a = 1'b1;
    step(1);                       // C0
    start_a = 1'b0;
    chk("a_r2_score0", score_a, 0);
    chk("a_r2_tl0",    tl_a,    2);
    chk("a_r2_hs0",    hs_a,    7);
    chk("a_r2_dv0",    dv_a,    0);
    step(4);
    start_a = 1'b1;
    step(1);                       // C5: ignored edge
    start_a = 1'b0;
    step(4);                       // C9
    chk("a_r2_tl9", tl_a, 2);
    step(1);                       // C10
    chk("a_r2_tl10", tl_a, 1);
    step(10);                      // C20: PLAYING
    chk("a_r2_tl20", tl_a, 3);
    step(5);
    start_a = 1'b1;
    step(1);                       // C26: ignored edge
    start_a = 1'b0;
    step(3);                       // C29
    chk("a_r2_tl29", tl_a, 3);
    chk("a_r2_ra29", ra_a, 1);
    step(1);                       // C30
    chk("a_r2_tl30", tl_a, 2);
    step(20);                      // C50
    chk("a_r2_go",    go_a,    1);
    chk("a_r2_score", score_a, 0);
    step(1);
    chk("a_r2_hs", hs_a, 7);
    chk("a_r2_dv", dv_a, 0);

    // ---- 6: reset during PLAYING with score 4 ----
    start_a = 1'b1;
    step(1);                       // D0
    start_a = 1'b0;
    step(20);                      // D20
    hit_a = 1'b1;
    step(16);                      // D36
    chk("a_r3_score36", score_a, 4);
    rst_a = 1'b1;
    hit_a = 1'b0;
    step(1);
    chk("a_mid_score", score_a, 0);
    chk("a_mid_hs",    hs_a,    0);
    chk("a_mid_tl",    tl_a,    0);
    chk("a_mid_dv",    dv_a,    0);
    chk("a_mid_ra",    ra_a,    0);
    chk("a_mid_go",    go_a,    0);

    // ---- 5: start held across reset release stays IDLE ----
    start_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    step(15);
    chk("a_held_tl", tl_a, 0);
    chk("a_held_ra", ra_a, 0);
    chk("a_held_go", go_a, 0);
    chk("a_idle_dv", dv_a, 0);     // IDLE shows high_score (0 after reset)
    start_a = 1'b0;
    step(1);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    chk("a_after_held_tl", tl_a, 2);

    // ---- 4: saturation at SCORE_MAX=5 ----
    step(2);
    rst_b = 1'b0;
    step(1);
    start_b = 1'b1;
    step(1);                       // B0
    start_b = 1'b0;
    step(20);                      // B20: PLAYING
    chk("b_pl_tl", tl_b, 3);
    hit_b = 1'b1;
    step(20);                      // B40: ticks 25,30,35,40
    chk("b_score40", score_b, 4);
    step(5);                       // B45
    chk("b_score45", score_b, 5);
    step(5);                       // B50: sixth tick saturates
    chk("b_sat_score", score_b, 5);
    chk("b_sat_go",    go_b,    1);
    step(1);
    hit_b = 1'b0;
    chk("b_sat_hs", hs_b, 5);
    chk("b_sat_dv", dv_b, 5);

    // ---- 6: hit only on the cycle of the final second tick ----
    start_b = 1'b1;
    step(1);                       // R0
    start_b = 1'b0;
    step(20);                      // R20
    step(29);                      // R49
    chk("b_last_score49", score_b, 0);
    chk("b_last_tl49",    tl_b,    1);
    chk("b_last_ra49",    ra_b,    1);
    hit_b = 1'b1;
    step(1);                       // R50
    hit_b = 1'b0;
    chk("b_last_score", score_b, 1);
    chk("b_last_go",    go_b,    1);
    chk("b_last_tl",    tl_b,    0);
    step(1);
    chk("b_last_hs", hs_b, 5);
    chk("b_last_dv", dv_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
